// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// A buffer entry pairs each fetched word with the PC it came from.
package fetch_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage signal bundle: instruction-memory port, redirect input and decode handshake.
// The master modport is the fetch stage; the slave modport is its environment.
interface instr_fetch_if;
  import fetch_pkg::*;

  logic [XLEN-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [XLEN-1:0]    out_pc;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );

endinterface

// File: rtl/fetch_buffer.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush.
// full/empty are registered from the next-state count so the consumer sees clean flags.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  // A push into a full buffer is legal only when the head leaves in the same cycle.
  always_comb begin
    do_pop    = pop & ~empty;
    do_push   = push & (~full | do_pop);
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (do_push && !do_pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_nxt = count - CNT_W'(1);
    end else begin
      count_nxt = count;
    end
  end

  // Storage, pointers and flags; flush drops every entry without clearing storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (do_push) begin
          mem[wr_ptr] <= wdata;
          wr_ptr      <= wr_ptr + PTR_W'(1);
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
      count <= count_nxt;
      empty <= (count_nxt == CNT_W'(0));
      full  <= (count_nxt == CNT_W'(DEPTH));
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, reads the combinational instruction memory
// and queues {pc, instr} pairs for decode; a redirect flushes the queue and reloads the PC.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input logic           clk,
  input logic           reset,
  instr_fetch_if.master bus
);

  logic [XLEN-1:0] pc;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  fetch_entry_t    wdata;
  fetch_entry_t    rdata;

  // Redirect overrides both sides; a full buffer still accepts a fetch while its head drains.
  always_comb begin
    pop         = ~empty & bus.out_ready & ~bus.redirect_valid;
    push        = ~bus.redirect_valid & (~full | pop);
    wdata.pc    = pc;
    wdata.instr = bus.imem_data;
  end

  // Program counter: a stalled fetch keeps the address so the same word is re-read.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      pc <= align_pc(bus.redirect_pc);
    end else if (push) begin
      pc <= pc + 32'd4;
    end else begin
      pc <= pc;
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  assign bus.imem_addr = pc;
  assign bus.out_valid = ~empty;
  assign bus.out_instr = rdata.instr;
  assign bus.out_pc    = rdata.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a reference model pushes expected {pc, instr} entries into a
// scoreboard queue as fetches happen, and each delivered head is compared against it.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic clk = 1'b0;
  logic reset;

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr[31:2] == 30'd0) begin
      return 32'h0011_0233;
    end else if (addr[31:2] == 30'd1) begin
      return 32'h4011_0293;
    end else begin
      return {addr[31:2], 2'b11} ^ 32'h5A5A_0000;
    end
  endfunction

  assign bus.imem_data = mem_word(bus.imem_addr);

  int           n_tests = 0;
  int           n_fail  = 0;
  fetch_entry_t sb[$];
  logic [31:0]  m_pc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then advance the model.
  task automatic step(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
    logic         pop;
    logic         push;
    fetch_entry_t e;
    @(negedge clk);
    reset              = rst;
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #1;
    check_eq("imem_addr", bus.imem_addr, m_pc);
    check_eq("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
    if (sb.size() != 0 && bus.out_valid) begin
      check_eq("out_pc", bus.out_pc, sb[0].pc);
      check_eq("out_instr", bus.out_instr, sb[0].instr);
    end
    pop  = (sb.size() != 0) && rdy && !rv && !rst;
    push = !rst && !rv && ((sb.size() < DEPTH) || pop);
    if (rst) begin
      sb.delete();
      m_pc = RESET_PC;
    end else if (rv) begin
      sb.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (pop) begin
        void'(sb.pop_front());
      end
      if (push) begin
        e.pc    = m_pc;
        e.instr = mem_word(m_pc);
        sb.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    reset              = 1'b1;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    m_pc               = RESET_PC;

    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("reset_out_pc", bus.out_pc, 32'h0);
    check_eq("reset_out_instr", bus.out_instr, 32'h0);

    // streaming, then a stall that fills the buffer, then drain
    repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (5) step(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0);

    // redirect while full, misaligned target, wrap at the top of the address space
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0024);
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0027);
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0);

    repeat (300) step(1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), $urandom);

    // reset while full with decode ready
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage for the single-cycle/multi-cycle RISC-V cores. It owns the program counter, drives the address of the combinational instruction memory, and captures each returned word with its PC into a small instruction buffer. Decode consumes that buffer through a valid/ready handshake. Control redirects (branch, jal, jalr) flush the buffer and reload the PC.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- DEPTH, 2, instruction buffer entries (power of two, ≥2)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- imem_addr  out  32  byte address to instruction memory (word index = imem_addr[31:2]); equals current PC
- imem_data  in  32  instruction word, combinational from imem_addr in the same cycle
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_pc  in  32  target PC; bits [1:0] forced to 0 internally
- out_valid  out  1  buffer head holds a valid instruction
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  32  head instruction
- out_pc  out  32  PC of head instruction

## Operation
- State: pc register; buffer of DEPTH entries {pc, instr}; rd_ptr and wr_ptr (modulo DEPTH); count (0..DEPTH).
- Pop: out_valid & out_ready & ~redirect_valid. Head advances, rd_ptr+1, count-1.
- Push (fetch): ~redirect_valid & (count < DEPTH | pop). Writes {pc, imem_data} at wr_ptr, wr_ptr+1, pc <= pc+4.
- Simultaneous push and pop: count unchanged. Full and popping: push still allowed.
- No push: pc holds and imem_addr holds, so the same word is re-read next cycle.
- Redirect (priority over push and pop):
  - count <= 0, pointers <= 0, pc <= {redirect_pc[31:2], 2'b00}.
  - The word fetched in this cycle is discarded.
  - A handshake in this cycle does not count as accepted.
- PC arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- out_valid = (count != 0). out_instr/out_pc = entry at rd_ptr. Contents are don't-care when out_valid = 0, but they read 0 after reset.
- Reset:
  - pc = RESET_PC, count = 0, pointers = 0, entries cleared.
  - Outputs: out_valid=0, out_instr=0, out_pc=0, imem_addr=RESET_PC.
  - Reset mid-operation discards all buffered instructions at that edge.

## Timing
- imem_addr comes straight from the pc register (no combinational input path).
- imem_data is sampled at the same edge the pc advances.
- Fetch-to-out_valid latency: 1 cycle. First instruction after reset release: fetched in cycle 0, out_valid=1 in cycle 1 with out_pc=RESET_PC.
- Redirect asserted in cycle N: target fetched in N+1, out_valid with out_pc=target in N+2.
- Steady state with out_ready held high: one instruction per cycle, consecutive PCs.
- out_ready low for k cycles: buffer fills to DEPTH, then fetch stalls; no instruction is lost or duplicated.
- out_ready→push is combinational through the pop term; out_valid/out_instr/out_pc are registered.

## Structure
- Shared package fetch_pkg:
  - INSTR_W=32, XLEN=32
  - NOP_INSTR=32'h0000_0013
  - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t
- Sub-module fetch_buffer: a DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty and count. instr_fetch keeps the pc register and the push/pop/redirect control.

## Test plan
- Reset release, out_ready=1, memory words 0x00110233, 0x40110293, … → cycle 1: out_pc=0x0, out_instr=0x00110233. Cycle 2: out_pc=0x4, out_instr=0x40110293. PC increments by 4 every cycle.
- out_ready=0 from cycle 1 for 5 cycles → count saturates at 2, imem_addr frozen at 0x8. Releasing out_ready delivers PCs 0x0, 0x4, 0x8 in order with no gaps or repeats.
- redirect_valid=1, redirect_pc=0x24 in cycle N while the buffer holds 0x8, 0xC → both discarded. out_valid=0 in N+1; out_pc=0x24 in N+2.
- redirect_pc=0x27 → PC loads 0x24 (low bits forced to 0).
- Redirect to 0xFFFF_FFFC → next PCs are 0xFFFF_FFFC then 0x0000_0000.
- reset asserted while full with out_ready=1 → next edge: out_valid=0, imem_addr=RESET_PC. After release, delivery restarts at RESET_PC.
